// File: rtl/sram_ctrl_pkg.sv
// Shared FSM encodings and default SRAM geometry for the sram_ctrl initiator.
// Also used by the SRAM array integration so both sides agree on widths.
package sram_ctrl_pkg;

  localparam int SRAM_BW_DATA = 64;
  localparam int SRAM_BW_ADDR = 6;
  localparam int SRAM_RD_LAT  = 1;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_RD_WAIT = 2'd2,
    ST_RESP    = 2'd3
  } state_t;

  // Width of a down-counter that must hold the value lat.
  function automatic int cnt_width(input int lat);
    return (lat < 1) ? 1 : $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// SRAM initiator: valid/ready request front end, registered SRAM pin timing, one read in flight.
// Build option SRAM_CTRL_INIT_EN adds a post-reset zero-fill sweep of the whole array.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int BW_DATA = SRAM_BW_DATA,
  parameter int BW_ADDR = SRAM_BW_ADDR,
  parameter int RD_LAT  = SRAM_RD_LAT
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_wr,
  input  logic [BW_ADDR-1:0] i_req_addr,
  input  logic [BW_DATA-1:0] i_req_data,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [BW_DATA-1:0] o_rsp_data,
  output logic               o_sram_cen,
  output logic               o_sram_wen,
  output logic               o_sram_oen,
  output logic [BW_ADDR-1:0] o_sram_addr,
  output logic [BW_DATA-1:0] o_sram_data,
  input  logic [BW_DATA-1:0] i_sram_data
);

  localparam int               CNT_W    = cnt_width(RD_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT);

  state_t             r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_req_ready;
  logic               r_rsp_valid;
  logic [BW_DATA-1:0] r_rsp_data;
  logic               r_cen;
  logic               r_wen;
  logic               r_oen;
  logic [BW_ADDR-1:0] r_addr;
  logic [BW_DATA-1:0] r_wdata;
  logic               w_req_fire;

`ifdef SRAM_CTRL_INIT_EN
  logic [BW_ADDR-1:0] r_init_addr;
  localparam state_t  RST_STATE = ST_INIT;
`else
  localparam state_t  RST_STATE = ST_IDLE;
`endif

  assign w_req_fire = r_req_ready & i_req_valid;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state     <= RST_STATE;
      r_cnt       <= '0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_cen       <= 1'b0;
      r_wen       <= 1'b0;
      r_oen       <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
`ifdef SRAM_CTRL_INIT_EN
      r_init_addr <= '0;
`endif
    end else begin
      // Command strobes are single-cycle pulses unless re-armed below.
      r_cen <= 1'b0;
      r_wen <= 1'b0;
      case (r_state)
`ifdef SRAM_CTRL_INIT_EN
        ST_INIT: begin
          r_cen       <= 1'b1;
          r_wen       <= 1'b1;
          r_oen       <= 1'b0;
          r_addr      <= r_init_addr;
          r_wdata     <= '0;
          r_init_addr <= r_init_addr + BW_ADDR'(1);
          if (&r_init_addr) begin
            r_state     <= ST_IDLE;
            r_req_ready <= 1'b1;
          end
        end
`endif
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          r_oen       <= 1'b0;
          if (w_req_fire) begin
            r_cen  <= 1'b1;
            r_wen  <= i_req_wr;
            r_addr <= i_req_addr;
            if (i_req_wr) begin
              r_wdata <= i_req_data;
            end else begin
              r_oen       <= 1'b1;
              r_req_ready <= 1'b0;
              r_cnt       <= CNT_LOAD;
              r_state     <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          // Counter reaches zero in the last cycle the SRAM drives valid data.
          if (r_cnt == '0) begin
            r_rsp_data  <= i_sram_data;
            r_rsp_valid <= 1'b1;
            r_oen       <= 1'b0;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_req_ready = r_req_ready;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_sram_cen  = r_cen;
  assign o_sram_wen  = r_wen;
  assign o_sram_oen  = r_oen;
  assign o_sram_addr = r_addr;
  assign o_sram_data = r_wdata;

endmodule
